io_out_fifo: RTL
================

IO_OUT_FIFO -- requirements
Module: io_out_fifo

Interface
REQ-001 Parameter NUBITS, default 16: data word width, equal to the processor word width.
REQ-002 Parameter NBIOOU, default 2: output port address width.
REQ-003 Parameter FDEPTH, default 8: FIFO entries; power of two, 2 or more.
REQ-004 clk  in  1  single clock; all logic rising-edge triggered.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 out_en  in  1  processor output strobe; one write request per cycle high.
REQ-007 addr_out  in  NBIOOU  processor output port address, sampled with out_en.
REQ-008 io_out  in  NUBITS  processor output data, sampled with out_en.
REQ-009 m_valid  out  1  head entry present on m_data/m_addr.
REQ-010 m_ready  in  1  sink accepts the head entry.
REQ-011 m_data  out  NUBITS  head entry data.
REQ-012 m_addr  out  NBIOOU  head entry port address.
REQ-013 full  out  1  FIFO holds FDEPTH entries.
REQ-014 count  out  $clog2(FDEPTH)+1  current occupancy.
REQ-015 ovf  out  1  sticky flag; a write was dropped.
REQ-016 ovf_clr  in  1  clears ovf.

Function
REQ-017 The FIFO shall store {addr_out, io_out} pairs in arrival order and present them first-word-fall-through.
REQ-018 Push shall occur on a cycle with out_en=1 and (full=0 or pop in the same cycle).
REQ-019 Pop shall occur on a cycle with m_valid=1 and m_ready=1.
REQ-020 A word pushed into an empty FIFO at edge N shall appear with m_valid=1 in the cycle following edge N (1-cycle latency); there shall be no combinational path from out_en/io_out to m_*.
REQ-021 m_data, m_addr and m_valid shall hold stable while m_valid=1 and m_ready=0.
REQ-022 Simultaneous push and pop shall leave count unchanged, including when full (write accepted) and when count=1 (new word becomes head next cycle).
REQ-023 Push and pop with m_valid=0 shall perform push only; m_ready shall be ignored when empty.
REQ-024 Read/write pointers shall be $clog2(FDEPTH) bits and wrap modulo FDEPTH; count shall range 0..FDEPTH.
REQ-025 full shall be 1 when count=FDEPTH; m_valid shall be 1 when count>0; both shall be derived from registered state.
REQ-026 out_en=1 while full=1 without a pop shall drop the word, leave the contents unchanged, and set ovf the next cycle.
REQ-027 ovf shall stay 1 until ovf_clr=1 or rst=1; if ovf_clr and a new overflow coincide, ovf shall remain 1.
REQ-028 m_data/m_addr shall be don't-care while m_valid=0 but shall not be X after reset; storage shall not need reset.

Reset
REQ-029 With rst=1 at an edge: pointers=0, count=0, m_valid=0, full=0, ovf=0, m_data=0, m_addr=0.
REQ-030 rst shall override simultaneous push/pop; entries in flight shall be discarded.
REQ-031 Push shall be accepted on the first edge after rst deasserts.

Verification
REQ-032 Reset, then out_en with addr=1, data=0x1234, m_ready=0 -> next cycle m_valid=1, m_addr=1, m_data=0x1234, count=1; held for 5 cycles.
REQ-033 Push 8 words 0..7 (FDEPTH=8), m_ready=0 -> full=1, count=8; ninth push data=0x00FF -> ovf=1, count=8; drain with m_ready=1 -> 0..7 in order, 0x00FF absent.
REQ-034 Full FIFO, out_en and m_ready both 1 for 20 cycles with incrementing data -> count stays 8, output sequence contiguous, ovf=0, pointers wrap.
REQ-035 Single entry, push 0xAAAA and pop in the same cycle -> next cycle m_data=0xAAAA, count=1; with no further push, after the next pop m_valid=0.
REQ-036 4 entries loaded, rst=1 for one cycle with out_en=1 -> count=0, m_valid=0, ovf=0; ovf_clr after overflow -> ovf=0 next cycle.
REQ-037 Random out_en/m_ready for 10k cycles against a scoreboard -> no loss except counted drops on full, order preserved, count matches the model.

Source files
------------

// File: rtl/io_out_fifo.sv
// io_out_fifo: first-word-fall-through FIFO between the processor output
// strobe and a valid/ready sink. Each entry carries {port address, data}.
// Words that arrive while the FIFO is full (and nothing is leaving) are
// dropped, and the sticky ovf flag records the loss.
//
// Handshake: the sink side uses strict valid/ready. A transfer happens on a
// rising edge where m_valid=1 and m_ready=1. While m_valid=1 and m_ready=0,
// m_valid, m_data and m_addr hold stable. m_ready is ignored while m_valid=0.
// The write side has no back-pressure: out_en is a one-shot strobe.
module io_out_fifo #(
    parameter int NUBITS = 16,
    parameter int NBIOOU = 2,
    parameter int FDEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      out_en,
    input  logic [NBIOOU-1:0]         addr_out,
    input  logic [NUBITS-1:0]         io_out,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [NUBITS-1:0]         m_data,
    output logic [NBIOOU-1:0]         m_addr,
    output logic                      full,
    output logic [$clog2(FDEPTH):0]   count,
    output logic                      ovf,
    input  logic                      ovf_clr
);

    localparam int PW = $clog2(FDEPTH);
    localparam int CW = PW + 1;
    localparam int EW = NBIOOU + NUBITS;

    logic [EW-1:0] mem [FDEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          ovf_q;
    logic          push;
    logic          pop;
    logic          drop;
    logic [EW-1:0] head;

    // Status flags come only from the registered occupancy, so there is no
    // combinational path from the write side to the sink side.
    assign m_valid = (cnt != '0);
    assign full    = (cnt == CW'(FDEPTH));
    assign count   = cnt;
    assign ovf     = ovf_q;

    // A pop frees a slot in the same edge, so a full FIFO still accepts a
    // write when the sink is taking the head.
    assign pop  = m_valid && m_ready;
    assign push = out_en && (!full || pop);
    assign drop = out_en && full && !pop;

    // Storage is never reset; the head is forced to zero while empty so the
    // outputs are defined straight out of reset.
    assign head   = mem[rd_ptr];
    assign m_data = m_valid ? head[NUBITS-1:0]  : '0;
    assign m_addr = m_valid ? head[EW-1:NUBITS] : '0;

    // Entry write at the write pointer; no reset needed on the data array.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {addr_out, io_out};
        end
    end

    // Pointers wrap naturally modulo FDEPTH (power of two).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Occupancy: simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Sticky overflow: a new drop wins over a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end else if (ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

endmodule
